clk_ratio_meter: RTL
====================

Name: clk_ratio_meter

Overview:
Measures an incoming slow clock (for example, a divider output such as a 4.5x divided clock) against the system clock `clk`. It counts `clk` cycles across WIN full periods of `clk_in` and reports the total. A fractional divide ratio R therefore reads back as WIN*R, exact whenever WIN*R is an integer. It is the checking end of the clock-divider blocks: used in self-test and by benches to confirm the divide ratio without waveform inspection.

Parameters:
WIN, 8, number of clk_in rising-edge periods per measurement (>=1)
CNT_W, 16, width of the cycle counter and result
TIMEOUT_CYC, 1024, clk cycles with no clk_in rising edge before the measurement aborts (>=4)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clk_in  input  1  clock under measurement, asynchronous to clk
start  input  1  one-cycle request to begin a measurement
busy  output  1  high while a measurement is in progress
done  output  1  one-cycle pulse when the result is valid
cycles  output  CNT_W  measured clk cycles over WIN periods
timeout  output  1  result invalid (no edge, or counter saturated)

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. Synchroniser flops, edge flop and all counters cleared. busy=0, done=0, cycles=0, timeout=0.
- Input path: clk_in passes through a 2-flop synchroniser s1->s2, plus a third flop s3. rise = s2 & ~s3. The fixed 3-cycle latency cancels out of the measurement.
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - busy=0.
  - start=1 -> ARM. Clear period counter, cycle counter and idle counter.
  - cycles and timeout keep their last values until start is accepted. They are cleared to 0 on that same edge.
- ARM:
  - busy=1. Waits for the first rise (the reference edge).
  - On rise -> COUNT, cycle counter := 0, period counter := 0.
- COUNT:
  - busy=1. Cycle counter increments by 1 every clk.
  - On each rise, period counter increments.
  - On the rise that makes the period count equal WIN -> DONE. cycles := cycle counter + 1, the clk count from the reference-edge cycle (exclusive) to the final-edge cycle (inclusive).
  - Constant period P gives cycles = WIN*P. Alternating 4/5 periods give cycles = 36 for WIN=8.
- Timeout:
  - The idle counter clears on entry to ARM and on every rise, and increments every other cycle in ARM or COUNT.
  - When it reaches TIMEOUT_CYC -> DONE with timeout=1, cycles=0.
- Saturation: if the cycle counter would pass 2^CNT_W-1 -> DONE with timeout=1, cycles=0. There is no wrap-around.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. cycles and timeout are registered and stable from the done cycle onward.
- Simultaneous events:
  - start while in ARM, COUNT or DONE: ignored, no restart.
  - rise and timeout threshold in the same cycle: rise wins and the idle counter clears.
  - WIN-th rise and saturation in the same cycle: saturation wins.
- Reset mid-measurement: immediate return to reset values. No done pulse, no partial result.
- clk_in must be slower than clk/2 (each high and low phase at least 1 clk period). Faster inputs give undefined counts but must never hang the FSM; timeout still applies.

Test Plan:
- Div-4.5 source (20 ns clk driving the 4.5x divider), WIN=8, start after reset release -> one done pulse, cycles=36, timeout=0, busy high from the cycle after start until done.
- Divide-by-4 source, WIN=8 -> cycles=32. Then divide-by-5 source, WIN=8 -> cycles=40. Back-to-back starts each give an independent result.
- WIN=1 with div-4.5 source, repeated 10 times -> every result is 4 or 5, and the 10 results include both values.
- clk_in held at 0, start -> done with timeout=1, cycles=0, at TIMEOUT_CYC+1 cycles after start (+/-1). busy=0 afterward.
- start re-pulsed 3 times during COUNT with div-4 source -> single done, cycles=32, no restart.
- rst_n low for 1 cycle mid-COUNT -> busy, done, cycles and timeout read 0 immediately. A new start after release gives a correct result (36 with the div-4.5 source).

Source files
------------

// File: rtl/clk_ratio_meter.sv
// Counts clk cycles across WIN full periods of an asynchronous clk_in, giving
// the clk:clk_in ratio scaled by WIN. Aborts on a stalled input or counter overflow.
module clk_ratio_meter #(
    parameter int WIN         = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles,
    output logic             timeout
);

    localparam int PW = $clog2(WIN + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(WIN - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [CNT_W-1:0] cyc_q;
    logic [PW-1:0]    per_q;
    logic [IW-1:0]    idle_q;
    logic             busy_q, done_q, timeout_q;
    logic [CNT_W-1:0] cycles_q;

    // s3 only provides edge detection; the fixed latency cancels between edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            per_q     <= '0;
            idle_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ARM;
                        busy_q    <= 1'b1;
                        cycles_q  <= '0;
                        timeout_q <= 1'b0;
                        cyc_q     <= '0;
                        per_q     <= '0;
                        idle_q    <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state_q <= COUNT;
                        cyc_q   <= '0;
                        per_q   <= '0;
                        idle_q  <= '0;
                    end else if (idle_q == IDLE_MAX) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cycles_q  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                COUNT: begin
                    // saturation is checked first so it beats a coincident final edge
                    if (cyc_q == {CNT_W{1'b1}}) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cycles_q  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                        if (rise) begin
                            idle_q <= '0;
                            if (per_q == PER_LAST) begin
                                state_q  <= DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                cycles_q <= cyc_q + CNT_W'(1);
                            end else begin
                                per_q <= per_q + PW'(1);
                            end
                        end else if (idle_q == IDLE_MAX) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            cycles_q  <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            idle_q <= idle_q + IW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cycles  = cycles_q;
    assign timeout = timeout_q;

endmodule
